// File: rtl/frame_streamer_pkg.sv
// Shared types and widths for the frame-buffer raster streamer and the
// downstream filter chain that consumes its pixel stream.
package frame_streamer_pkg;

  localparam int PIXEL_W  = 16;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP,
    ST_DRAIN
  } fs_state_t;

  // Position tag that travels alongside each BRAM read.
  typedef struct packed {
    logic                valid;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
  } pixel_tag_t;

  localparam int TAG_W = $bits(pixel_tag_t);

  function automatic int addr_width(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Bus bundle for frame_streamer: start/busy/done control, BRAM read port and
// the outgoing pixel stream. master = streamer side, slave = system side.
interface frame_streamer_if #(
  parameter int ADDR_W = 17
);
  import frame_streamer_pkg::*;

  // Stream semantics: data_valid_out is a pure strobe with no back-pressure;
  // pixel_data_out/hcount_out/vcount_out are meaningful (and held) around it.
  logic                start_in;
  logic                busy_out;
  logic                frame_done_out;
  logic                rd_en_out;
  logic [ADDR_W-1:0]   addr_out;
  logic [PIXEL_W-1:0]  rd_data_in;
  logic                data_valid_out;
  logic [PIXEL_W-1:0]  pixel_data_out;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  fs_state_t           dbg_state;

  modport master (
    input  start_in,
    input  rd_data_in,
    output busy_out,
    output frame_done_out,
    output rd_en_out,
    output addr_out,
    output data_valid_out,
    output pixel_data_out,
    output hcount_out,
    output vcount_out,
    output dbg_state
  );

  modport slave (
    output start_in,
    output rd_data_in,
    input  busy_out,
    input  frame_done_out,
    input  rd_en_out,
    input  addr_out,
    input  data_valid_out,
    input  pixel_data_out,
    input  hcount_out,
    input  vcount_out,
    input  dbg_state
  );

endinterface

// File: rtl/frame_streamer_stream_delay.sv
// Fixed-depth shift register used to align read tags with BRAM read latency.
// All stages clear on reset so no stale tag survives.
module stream_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/frame_streamer.sv
// Raster-scan transmitter: reads a stored frame from BRAM and emits it as a
// data_valid/pixel/hcount/vcount stream. Define FRAME_STREAMER_LOOP_EN to
// stream frames back to back after the first start_in.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int READ_LATENCY = 2,
  parameter int PIXEL_PERIOD = 1,
  parameter int LINE_GAP     = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  frame_streamer_if.master bus
);

  localparam int ADDR_W = addr_width(H_ACTIVE * V_ACTIVE);
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0]    PACE_LAST  = CNT_W'(PIXEL_PERIOD - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(LINE_GAP - 1);
  localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'(READ_LATENCY);
  localparam logic [HCOUNT_W-1:0] H_LAST     = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST     = VCOUNT_W'(V_ACTIVE - 1);
`ifdef FRAME_STREAMER_LOOP_EN
  localparam logic [CNT_W-1:0]    DRAIN_WRAP = CNT_W'(READ_LATENCY + 1);
`endif

  fs_state_t           state;
  logic [CNT_W-1:0]    cnt;
  logic [HCOUNT_W-1:0] h;
  logic [VCOUNT_W-1:0] v;
  logic [ADDR_W-1:0]   addr;
  logic                rd_en;
  logic                busy;
  logic                frame_done;

  pixel_tag_t tag_in;
  pixel_tag_t tag_out;

  logic                valid_q;
  logic [PIXEL_W-1:0]  pixel_q;
  logic [HCOUNT_W-1:0] hcount_q;
  logic [VCOUNT_W-1:0] vcount_q;

  // rd_en/addr/h/v are updated together with state so that, in any cycle,
  // they describe the read actually on the BRAM port. cnt is shared: pixel
  // pace in ACTIVE, gap length in GAP, drain length in DRAIN.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      h          <= '0;
      v          <= '0;
      addr       <= '0;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          h    <= '0;
          v    <= '0;
          addr <= '0;
          cnt  <= '0;
          if (bus.start_in) begin
            state <= ST_ACTIVE;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (h == H_LAST && v == V_LAST) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else if (cnt != PACE_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (h != H_LAST) begin
            h     <= h + 1'b1;
            addr  <= addr + 1'b1;
            cnt   <= '0;
            rd_en <= 1'b1;
          end else if (LINE_GAP > 0) begin
            state <= ST_GAP;
            cnt   <= '0;
          end else begin
            h     <= '0;
            v     <= v + 1'b1;
            addr  <= addr + 1'b1;
            cnt   <= '0;
            rd_en <= 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_ACTIVE;
            h     <= '0;
            v     <= v + 1'b1;
            addr  <= addr + 1'b1;
            cnt   <= '0;
            rd_en <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DRAIN: begin
`ifdef FRAME_STREAMER_LOOP_EN
          // One extra idle cycle carries the done pulse before the next frame.
          if (cnt == DRAIN_WRAP) begin
            state <= ST_ACTIVE;
            h     <= '0;
            v     <= '0;
            addr  <= '0;
            cnt   <= '0;
            rd_en <= 1'b1;
          end else begin
            if (cnt == DRAIN_LAST) begin
              frame_done <= 1'b1;
            end
            cnt <= cnt + 1'b1;
          end
`else
          if (cnt == DRAIN_LAST) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tag_in = '{valid: rd_en, hcount: h, vcount: v};

  stream_delay #(
    .DEPTH (READ_LATENCY),
    .WIDTH (TAG_W)
  ) u_tag_delay (
    .clk (clk_in),
    .rst (rst_in),
    .d   (tag_in),
    .q   (tag_out)
  );

  // Output stage: pixel fields only move on a valid tag, otherwise they hold.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q  <= 1'b0;
      pixel_q  <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      valid_q <= tag_out.valid;
      if (tag_out.valid) begin
        pixel_q  <= bus.rd_data_in;
        hcount_q <= tag_out.hcount;
        vcount_q <= tag_out.vcount;
      end
    end
  end

  assign bus.busy_out       = busy;
  assign bus.frame_done_out = frame_done;
  assign bus.rd_en_out      = rd_en;
  assign bus.addr_out       = addr;
  assign bus.data_valid_out = valid_q;
  assign bus.pixel_data_out = pixel_q;
  assign bus.hcount_out     = hcount_q;
  assign bus.vcount_out     = vcount_q;
  assign bus.dbg_state      = state;

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer: small 4x3 frames (P=1 and P=3), start
// filtering, mid-frame reset, and one full 320x240 frame with L=1.
module tb_frame_streamer;
  import frame_streamer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_bc;

  int n_cmp = 0;
  int n_bad = 0;

  frame_streamer_if #(.ADDR_W(4))  bus_a ();
  frame_streamer_if #(.ADDR_W(4))  bus_b ();
  frame_streamer_if #(.ADDR_W(17)) bus_c ();

  frame_streamer #(
    .H_ACTIVE(4), .V_ACTIVE(3), .READ_LATENCY(2), .PIXEL_PERIOD(1), .LINE_GAP(2)
  ) dut_a (.clk_in(clk), .rst_in(rst_a), .bus(bus_a));

  frame_streamer #(
    .H_ACTIVE(4), .V_ACTIVE(3), .READ_LATENCY(2), .PIXEL_PERIOD(3), .LINE_GAP(2)
  ) dut_b (.clk_in(clk), .rst_in(rst_bc), .bus(bus_b));

  frame_streamer #(
    .H_ACTIVE(320), .V_ACTIVE(240), .READ_LATENCY(1), .PIXEL_PERIOD(1), .LINE_GAP(0)
  ) dut_c (.clk_in(clk), .rst_in(rst_bc), .bus(bus_c));

  // BRAM models, mem[a] = a, latency 2 / 2 / 1
  logic [15:0] a_p1 = '0, a_p2 = '0;
  logic [15:0] b_p1 = '0, b_p2 = '0;
  logic [15:0] c_p1 = '0;

  always @(posedge clk) begin
    if (bus_a.rd_en_out) a_p1 <= 16'(bus_a.addr_out);
    a_p2 <= a_p1;
    if (bus_b.rd_en_out) b_p1 <= 16'(bus_b.addr_out);
    b_p2 <= b_p1;
    if (bus_c.rd_en_out) c_p1 <= 16'(bus_c.addr_out);
  end

  assign bus_a.rd_data_in = a_p2;
  assign bus_b.rd_data_in = b_p2;
  assign bus_c.rd_data_in = c_p1;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // 4x3 frame, L=2, GAP=2: reads at 1+6v+h, pixels 3 cycles later, done at
  // 20, busy 1..19. Frames repeat every 20 cycles for n_frames.
  task automatic run_a(input int pulse_c, input int n_frames, input int end_c);
    int e_rd, e_addr, e_vld, e_pix, e_done, e_busy, k, r;
    for (int c = 0; c <= end_c; c++) begin
      bus_a.start_in = (c == 0) || (c == pulse_c);
      @(negedge clk);
      e_rd = 0; e_addr = 0; e_vld = 0; e_pix = 0; e_done = 0; e_busy = 0;
      for (int f = 0; f < n_frames; f++) begin
        k = c - 20 * f;
        if (k == 20) e_done = 1;
        if (k >= 1 && k <= 19) e_busy = 1;
        for (int vv = 0; vv < 3; vv++) begin
          for (int hh = 0; hh < 4; hh++) begin
            r = 1 + 6 * vv + hh;
            if (k == r) begin
              e_rd = 1;
              e_addr = 4 * vv + hh;
            end
            if (k == r + 3) begin
              e_vld = 1;
              e_pix = 4 * vv + hh;
            end
          end
        end
      end
`ifdef FRAME_STREAMER_LOOP_EN
      e_busy = (c >= 1) ? 1 : 0;
`endif
      check($sformatf("a_rd_en@%0d", c), 32'(bus_a.rd_en_out), e_rd);
      if (e_rd != 0) check($sformatf("a_addr@%0d", c), 32'(bus_a.addr_out), e_addr);
      check($sformatf("a_valid@%0d", c), 32'(bus_a.data_valid_out), e_vld);
      if (e_vld != 0) begin
        check($sformatf("a_pixel@%0d", c), 32'(bus_a.pixel_data_out), e_pix);
        check($sformatf("a_hcount@%0d", c), 32'(bus_a.hcount_out), e_pix % 4);
        check($sformatf("a_vcount@%0d", c), 32'(bus_a.vcount_out), e_pix / 4);
      end
      check($sformatf("a_done@%0d", c), 32'(bus_a.frame_done_out), e_done);
      check($sformatf("a_busy@%0d", c), 32'(bus_a.busy_out), e_busy);
      next_cycle();
    end
    bus_a.start_in = 1'b0;
  endtask

  task automatic reset_midframe();
    for (int c = 0; c < 9; c++) begin
      bus_a.start_in = (c == 0);
      @(negedge clk);
      if (c == 8) begin
        check("rs_pre_busy", 32'(bus_a.busy_out), 1);
        check("rs_pre_rd_en", 32'(bus_a.rd_en_out), 1);
      end
      next_cycle();
    end
    bus_a.start_in = 1'b0;
    rst_a = 1'b1;
    #1;
    check("rs_busy", 32'(bus_a.busy_out), 0);
    check("rs_done", 32'(bus_a.frame_done_out), 0);
    check("rs_rd_en", 32'(bus_a.rd_en_out), 0);
    check("rs_addr", 32'(bus_a.addr_out), 0);
    check("rs_valid", 32'(bus_a.data_valid_out), 0);
    check("rs_pixel", 32'(bus_a.pixel_data_out), 0);
    check("rs_hcount", 32'(bus_a.hcount_out), 0);
    check("rs_vcount", 32'(bus_a.vcount_out), 0);
    next_cycle();
    next_cycle();
    rst_a = 1'b0;
    for (int c = 11; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("rs_quiet_valid@%0d", c), 32'(bus_a.data_valid_out), 0);
      check($sformatf("rs_quiet_busy@%0d", c), 32'(bus_a.busy_out), 0);
      next_cycle();
    end
    run_a(-1, 1, 20);
  endtask

  // P=3: pixels in raster order, 3 cycles apart within a line.
  task automatic run_b();
    int n, last_c, done_c, seen;
    n = 0; last_c = 0; done_c = 0; seen = 0;
    bus_b.start_in = 1'b1;
    next_cycle();
    bus_b.start_in = 1'b0;
    for (int c = 1; c < 200 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_b.data_valid_out) begin
        if (n == 0) check("b_first_valid_cycle", c, 4);
        else if (n % 4 != 0) check($sformatf("b_spacing_%0d", n), c - last_c, 3);
        check($sformatf("b_pixel_%0d", n), 32'(bus_b.pixel_data_out), n);
        check($sformatf("b_hcount_%0d", n), 32'(bus_b.hcount_out), n % 4);
        check($sformatf("b_vcount_%0d", n), 32'(bus_b.vcount_out), n / 4);
        last_c = c;
        n++;
      end
      if (bus_b.frame_done_out) begin
        seen = 1;
        done_c = c;
      end
      next_cycle();
    end
    check("b_done_seen", seen, 1);
    check("b_pixel_count", n, 12);
    check("b_done_after_last", done_c, last_c + 1);
  endtask

  // Full 320x240 frame, L=1.
  task automatic run_c();
    int n, bad, eh, ev, first_c, done_c, seen, last_h, last_v;
    n = 0; bad = 0; eh = 0; ev = 0; first_c = 0; done_c = 0; seen = 0;
    last_h = 0; last_v = 0;
    bus_c.start_in = 1'b1;
    next_cycle();
    bus_c.start_in = 1'b0;
    for (int c = 1; c < 80000 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_c.data_valid_out) begin
        if (n == 0) first_c = c;
        if (bus_c.pixel_data_out !== 16'(n) || bus_c.hcount_out !== 11'(eh) ||
            bus_c.vcount_out !== 10'(ev)) bad++;
        last_h = int'(bus_c.hcount_out);
        last_v = int'(bus_c.vcount_out);
        n++;
        eh++;
        if (eh == 320) begin
          eh = 0;
          ev++;
        end
      end
      if (bus_c.frame_done_out) begin
        seen = 1;
        done_c = c;
      end
      next_cycle();
    end
    check("c_done_seen", seen, 1);
    check("c_pixel_count", n, 76800);
    check("c_pixel_errors", bad, 0);
    check("c_first_valid_cycle", first_c, 3);
    check("c_done_cycle", done_c, 76803);
    check("c_last_hcount", last_h, 319);
    check("c_last_vcount", last_v, 239);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus_a.start_in = 1'b0;
    bus_b.start_in = 1'b0;
    bus_c.start_in = 1'b0;
    rst_a = 1'b1;
    rst_bc = 1'b1;
    next_cycle();
    next_cycle();
    check("init_busy", 32'(bus_a.busy_out), 0);
    check("init_done", 32'(bus_a.frame_done_out), 0);
    check("init_rd_en", 32'(bus_a.rd_en_out), 0);
    check("init_valid", 32'(bus_a.data_valid_out), 0);
    check("init_pixel", 32'(bus_a.pixel_data_out), 0);
    rst_a = 1'b0;
    rst_bc = 1'b0;
    next_cycle();

`ifdef FRAME_STREAMER_LOOP_EN
    run_a(8, 3, 42);
    rst_a = 1'b1;
    next_cycle();
    rst_a = 1'b0;
    next_cycle();
`else
    run_a(8, 1, 24);
    run_a(20, 2, 42);
`endif
    reset_midframe();
    run_b();
    run_c();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
